// File: rtl/io_tile_bank.sv
// IO tile bank: serial config chain with shadow/active config and
// per-pin output/input data paths (optionally registered, invertible).
module io_tile_bank #(
    parameter int IO_COUNT = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                config_in,
    output logic                config_out,
    input  logic                config_enable,
    input  logic                config_commit,
    output logic                config_ready,
    output logic                config_error,
    input  logic [IO_COUNT-1:0] data_from_io,
    output logic [IO_COUNT-1:0] data_to_io,
    output logic [IO_COUNT-1:0] data_oe,
    input  logic [IO_COUNT-1:0] data_from_ic,
    output logic [IO_COUNT-1:0] data_to_ic
);

    localparam int CFG_BITS = 4 * IO_COUNT;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0] sr;
    logic [CFG_BITS-1:0] act;
    logic [CNT_W-1:0]    cnt;
    logic [IO_COUNT-1:0] oq;
    logic [IO_COUNT-1:0] iq;
    logic                err_q;
    logic                accept;

    assign config_out   = sr[CFG_BITS-1];
    assign config_ready = (cnt == CNT_FULL);
    assign config_error = err_q;
    assign accept       = config_commit && config_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr    <= '0;
            act   <= '0;
            cnt   <= '0;
            oq    <= '0;
            iq    <= '0;
            err_q <= 1'b0;
        end else begin
            oq    <= data_from_ic;
            iq    <= data_from_io;
            err_q <= config_commit && !config_ready;
            if (config_enable)
                sr <= {sr[CFG_BITS-2:0], config_in};
            // a shift coinciding with an accepted commit counts toward the next load
            if (accept) begin
                act <= sr;
                cnt <= config_enable ? CNT_W'(1) : '0;
            end else if (config_enable && !config_ready) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        data_to_io = '0;
        data_oe    = '0;
        data_to_ic = '0;
        for (int i = 0; i < IO_COUNT; i++) begin
            data_oe[i] = act[4*i];
            if (act[4*i])
                data_to_io[i] = (act[4*i+1] ? oq[i] : data_from_ic[i]) ^ act[4*i+3];
            data_to_ic[i] = act[4*i+2] ? iq[i] : data_from_io[i];
        end
    end

endmodule

// File: tb/tb_io_tile_bank.sv
// Directed and randomized bench for io_tile_bank (IO_COUNT=2) against
// a behavioural model of the config chain and pin data paths.
module tb_io_tile_bank;

    logic       clock;
    logic       reset;
    logic       config_in;
    logic       config_out;
    logic       config_enable;
    logic       config_commit;
    logic       config_ready;
    logic       config_error;
    logic [1:0] data_from_io;
    logic [1:0] data_to_io;
    logic [1:0] data_oe;
    logic [1:0] data_from_ic;
    logic [1:0] data_to_ic;

    int checks = 0;
    int errors = 0;

    // model state
    int unsigned m_sr;
    int unsigned m_act;
    int          m_nshift;
    int unsigned m_oq;
    int unsigned m_iq;
    int unsigned m_err;

    io_tile_bank #(.IO_COUNT(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .config_in     (config_in),
        .config_out    (config_out),
        .config_enable (config_enable),
        .config_commit (config_commit),
        .config_ready  (config_ready),
        .config_error  (config_error),
        .data_from_io  (data_from_io),
        .data_to_io    (data_to_io),
        .data_oe       (data_oe),
        .data_from_ic  (data_from_ic),
        .data_to_ic    (data_to_ic)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_sr = 0; m_act = 0; m_nshift = 0; m_oq = 0; m_iq = 0; m_err = 0;
    endtask

    task automatic check_all(input string tag);
        int unsigned e_io, e_oe, e_ic, f, ic_b, io_b, oq_b, iq_b, d;
        e_io = 0; e_oe = 0; e_ic = 0;
        for (int i = 0; i < 2; i++) begin
            f    = (m_act >> (4 * i)) % 16;
            ic_b = (data_from_ic >> i) & 1;
            io_b = (data_from_io >> i) & 1;
            oq_b = (m_oq >> i) % 2;
            iq_b = (m_iq >> i) % 2;
            if (f % 2 == 1) begin
                e_oe += (1 << i);
                d = ((f / 2) % 2 == 1) ? oq_b : ic_b;
                if (f / 8 == 1) d = 1 - d;
                e_io += d << i;
            end
            e_ic += (((f / 4) % 2 == 1) ? iq_b : io_b) << i;
        end
        chk({tag, ".cfg_out"}, 8'(config_out), 8'(m_sr / 128));
        chk({tag, ".ready"},   8'(config_ready), 8'(m_nshift >= 8));
        chk({tag, ".error"},   8'(config_error), 8'(m_err));
        chk({tag, ".oe"},      8'(data_oe), 8'(e_oe));
        chk({tag, ".to_io"},   8'(data_to_io), 8'(e_io));
        chk({tag, ".to_ic"},   8'(data_to_ic), 8'(e_ic));
    endtask

    task automatic model_edge();
        int ready;
        if (reset) begin
            model_clear();
            return;
        end
        ready = (m_nshift >= 8);
        m_err = (config_commit && !ready) ? 1 : 0;
        if (config_commit && ready) begin
            m_act    = m_sr;
            m_nshift = config_enable ? 1 : 0;
        end else if (config_enable) begin
            m_nshift++;
        end
        if (config_enable) m_sr = (m_sr * 2 + config_in) % 256;
        m_oq = data_from_ic;
        m_iq = data_from_io;
    endtask

    task automatic cycle(input string tag, input logic en, input logic din,
                         input logic cm, input logic [1:0] io, input logic [1:0] ic);
        config_enable = en;
        config_in     = din;
        config_commit = cm;
        data_from_io  = io;
        data_from_ic  = ic;
        #1 check_all(tag);
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic rcycle(input string tag, input logic en, input logic din, input logic cm);
        cycle(tag, en, din, cm, 2'($urandom), 2'($urandom));
    endtask

    task automatic shift_byte(input string tag, input logic [7:0] v);
        for (int i = 7; i >= 0; i--) rcycle(tag, 1'b1, v[i], 1'b0);
    endtask

    initial begin
        model_clear();
        reset = 1'b1;
        config_enable = 0; config_in = 0; config_commit = 0;
        data_from_io = 2'b10; data_from_ic = 2'b11;
        #1 check_all("reset");
        @(negedge clock);
        rcycle("reset_hold", 1'b1, 1'b1, 1'b1);
        reset = 1'b0;

        // enable pin 0 only, combinational
        shift_byte("s1_shift", 8'h03);
        rcycle("s1_commit", 1'b0, 1'b0, 1'b1);
        chk("s1_oe", 8'(data_oe), 8'h01);
        chk("s1_io1", 8'(data_to_io[1]), 8'h00);
        for (int i = 0; i < 4; i++) rcycle("s1_data", 1'b0, 1'b0, 1'b0);

        // short chain rejected, then completed
        for (int i = 0; i < 7; i++) rcycle("s2_shift", 1'b1, 1'b1, 1'b0);
        rcycle("s2_bad", 1'b0, 1'b0, 1'b1);
        chk("s2_err", 8'(config_error), 8'h01);
        chk("s2_oe_kept", 8'(data_oe), 8'h01);
        rcycle("s2_idle", 1'b0, 1'b0, 1'b0);
        chk("s2_err_clr", 8'(config_error), 8'h00);
        rcycle("s2_last", 1'b1, 1'b1, 1'b0);
        rcycle("s2_commit", 1'b0, 1'b0, 1'b1);
        chk("s2_no_err", 8'(config_error), 8'h00);
        chk("s2_oe", 8'(data_oe), 8'h03);
        for (int i = 0; i < 4; i++) rcycle("s2_data", 1'b0, 1'b0, 1'b0);

        // commit with concurrent shift
        shift_byte("s3_shift", 8'h19);
        rcycle("s3_commit", 1'b1, 1'b0, 1'b1);
        chk("s3_ready", 8'(config_ready), 8'h00);
        chk("s3_oe", 8'(data_oe), 8'h03);
        for (int i = 0; i < 3; i++) rcycle("s3_data", 1'b0, 1'b0, 1'b0);

        // pin 1 inverted combinational
        shift_byte("s4_shift", 8'h91);
        rcycle("s4_commit", 1'b0, 1'b0, 1'b0);
        rcycle("s4_commit", 1'b0, 1'b0, 1'b1);
        cycle("s4_drive", 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
        chk("s4_io1", 8'(data_to_io[1]), 8'h00);
        chk("s4_oe1", 8'(data_oe[1]), 8'h01);

        // pin 0 registered input
        shift_byte("s5_shift", 8'h04);
        rcycle("s5_commit", 1'b0, 1'b0, 1'b1);
        cycle("s5_lo", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        cycle("s5_pulse", 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        chk("s5_ic_hi", 8'(data_to_ic[0]), 8'h01);
        cycle("s5_lo2", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        chk("s5_ic_lo", 8'(data_to_ic[0]), 8'h00);

        // async reset mid-operation
        shift_byte("s6_shift", 8'hBB);
        rcycle("s6_commit", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) rcycle("s6_pre", 1'b1, 1'b1, 1'b0);
        #2 reset = 1'b1;
        model_clear();
        #1 check_all("s6_rst");
        chk("s6_cfg_out", 8'(config_out), 8'h00);
        chk("s6_oe", 8'(data_oe), 8'h00);
        @(negedge clock);
        rcycle("s6_hold", 1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) rcycle("s6_chain", 1'b1, 1'($urandom), 1'b0);
        rcycle("s6_commit2", 1'b0, 1'b0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            rcycle("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom),
                   1'($urandom_range(0, 7) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_tile_bank.md
IO_TILE_BANK -- requirements
Module: io_tile_bank

Interface
REQ-001 Parameter IO_COUNT, default 2, number of IO pins and fabric lanes (>=1).
REQ-002 Derived constant CFG_BITS = 4*IO_COUNT, config chain length; CNT_W = clog2(CFG_BITS+1), counter width.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clock  input  1  single clock for config chain, counter and data registers; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset of all state.
REQ-006 config_in  input  1  serial config bit, shifted in at bit 0.
REQ-007 config_out  output  1  serial config out; always shift-register MSB, for daisy-chaining tiles.
REQ-008 config_enable  input  1  shift enable for the config chain.
REQ-009 config_commit  input  1  request to copy shift register into active config.
REQ-010 config_ready  output  1  high when exactly CFG_BITS or more bits have been shifted since the last accepted commit or reset.
REQ-011 config_error  output  1  one-cycle pulse when a commit is rejected.
REQ-012 data_from_io  input  IO_COUNT  pad-side input data.
REQ-013 data_to_io  output  IO_COUNT  pad-side output data.
REQ-014 data_oe  output  IO_COUNT  pad output enable, per pin.
REQ-015 data_from_ic  input  IO_COUNT  fabric-side data toward pads.
REQ-016 data_to_ic  output  IO_COUNT  fabric-side data from pads.

Function
REQ-017 Shift register sr[CFG_BITS-1:0]: when config_enable=1, sr <= {sr[CFG_BITS-2:0], config_in}; otherwise it holds.
REQ-018 Per-pin active config field act[4i+3:4i]: bit0 out_enable, bit1 out_registered, bit2 in_registered, bit3 out_invert.
REQ-019 Bit order: the first bit shifted lands at sr MSB (pin IO_COUNT-1, out_invert); the last bit lands at sr[0] (pin 0, out_enable).
REQ-020 Shift counter cnt: increments on each cycle with config_enable=1 and saturates at CFG_BITS; config_ready = (cnt == CFG_BITS), combinational from cnt.
REQ-021 Commit accepted (config_commit=1 and config_ready=1): act <= sr using the pre-edge sr value; cnt <= 1 if config_enable=1 in the same cycle, else 0.
REQ-022 Commit rejected (config_commit=1 and config_ready=0): act and cnt updates are unaffected by the commit; config_error=1 for the next cycle only.
REQ-023 Shifting never alters act; live data paths see only committed config.
REQ-024 Output register oq[i] <= data_from_ic[i] every cycle; input register iq[i] <= data_from_io[i] every cycle.
REQ-025 data_to_io[i] = out_enable ? ((out_registered ? oq[i] : data_from_ic[i]) XOR out_invert) : 0.
REQ-026 data_oe[i] = out_enable.
REQ-027 data_to_ic[i] = in_registered ? iq[i] : data_from_io[i]. This path is independent of out_enable.
REQ-028 Latency: combinational paths have 0 cycles; registered paths have 1 cycle. A commit takes effect on outputs in the cycle after the accepting edge.
REQ-029 If config_enable is held more than CFG_BITS cycles, cnt stays at CFG_BITS and sr contains the last CFG_BITS bits.

Reset
REQ-030 On reset the following clear asynchronously to 0: sr, act, cnt, oq, iq and the config_error flop.
REQ-031 During reset the outputs are: config_out=0, config_ready=0, config_error=0, data_oe=0, data_to_io=0, and data_to_ic=data_from_io (combinational input mode).
REQ-032 Reset asserted mid-shift discards the partial chain; a full CFG_BITS shift is required before the next commit is accepted.

Verification
REQ-033 Scenario: IO_COUNT=2; shift 8'b0000_0011 MSB first, then commit -> data_oe=2'b01; data_to_io[0] follows data_from_ic[0] one cycle late; data_to_io[1]=0.
REQ-034 Scenario: shift 7 bits, then commit -> config_ready=0, config_error pulses for one cycle, act unchanged. Then shift 1 more bit and commit -> accepted, no error.
REQ-035 Scenario: commit and config_enable asserted in the same cycle when cnt=8 -> act gets the pre-shift sr, cnt=1, config_ready=0 next cycle.
REQ-036 Scenario: pin 1 config 4'b1001 (enable+invert, combinational), data_from_ic[1]=1 -> data_to_io[1]=0 in the same cycle; data_oe[1]=1.
REQ-037 Scenario: in_registered=1 on pin 0, pulse data_from_io[0] for 1 cycle -> data_to_ic[0] pulses exactly one cycle later.
REQ-038 Scenario: assert reset mid-operation after a valid config -> all outputs reach the REQ-031 values immediately; config_out=0; 16 shifted bits appear on config_out delayed by 8 cycles.
